ntt_engine: RTL
===============

Name: ntt_engine

Overview:
Parametrised iterative radix-2 NTT/INTT core with streaming load/unload and one butterfly per cycle. It uses a runtime mode select, and inverse mode applies the final N^-1 scaling. Coefficients stream in over a valid/ready interface, are transformed in place in an internal buffer, and stream out in natural order. Twiddles come from an external ROM through a combinational address/data port. The core sits between the polynomial sampler and the pointwise multiplier in the RLWE datapath.

Parameters:
N, 256, transform length; power of two, >= 4
LOG_N, 8, log2(N)
Q, 12289, prime modulus, Q = 1 mod 2N
DATA_WIDTH, 14, coefficient width, >= ceil(log2 Q)
N_INV, 12241, N^-1 mod Q, used by INTT scaling

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin a transform; sampled in IDLE only
inverse  in  1  mode latched on start: 0 = NTT, 1 = INTT
in_valid  in  1  input coefficient valid
in_ready  out  1  core accepts a coefficient (LOAD state)
in_data  in  DATA_WIDTH  input coefficient, natural order
out_valid  out  1  output coefficient valid (UNLOAD state)
out_ready  in  1  downstream accepts a coefficient
out_data  out  DATA_WIDTH  output coefficient, natural order
tw_addr  out  LOG_N-1  twiddle index, 0..N/2-1
tw_inv  out  1  latched mode; ROM returns omega^-addr when 1
tw_data  in  DATA_WIDTH  combinational ROM reply for the current tw_addr
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the last coefficient unloads

Behaviour:
- Reset (async, any state): state = IDLE. in_ready, out_valid, busy, done, tw_inv = 0. tw_addr, out_data = 0. Buffer contents undefined.
- IDLE: if start=1, latch inverse into tw_inv and go to LOAD. start is ignored in every other state.
- LOAD: in_ready=1. A coefficient transfers when in_valid and in_ready are both 1. Coefficient i (0-based count) is written, reduced mod Q, to buffer[bitrev_LOG_N(i)]. After the Nth transfer go to COMPUTE next cycle; in_ready drops in that same cycle.
- COMPUTE: stage s = 1..LOG_N, with half = 2^(s-1), m = 2*half. The butterfly counter b runs 0..N/2-1, one butterfly per cycle.
  - k = b mod half; j = (b / half)*m + k; tw_addr = k*(N/m).
  - t = (buffer[j+half]*tw_data) mod Q.
  - buffer[j] <= (u+t) mod Q; buffer[j+half] <= (u-t+Q) mod Q, where u = buffer[j].
  - The multiply product is 2*DATA_WIDTH wide; add and subtract use DATA_WIDTH+1 bits before reduction.
  - COMPUTE lasts exactly LOG_N*N/2 cycles.
  - When done: go to SCALE if tw_inv=1, else to UNLOAD.
- SCALE (INTT only): N cycles; buffer[i] <= (buffer[i]*N_INV) mod Q for i = 0..N-1, then go to UNLOAD.
- UNLOAD: out_valid=1, out_data = buffer[idx], idx starting at 0. idx advances on out_valid and out_ready both 1. out_data holds stable while out_ready=0.
  - After the Nth transfer: out_valid=0, done=1 for exactly one cycle, go to IDLE.
- Output is natural order and fully reduced, 0 <= value < Q.
- Reset mid-operation aborts immediately: no done pulse, and the next start begins a fresh LOAD.
- Back-to-back: start may be asserted in the cycle after done; the new LOAD begins the following cycle.

Optional Feature:
Macro NTT_RANGE_CHECK_EN.
- Defined: extra output port range_err (1 bit).
  - Set sticky when an accepted in_data is >= Q.
  - Cleared on reset and on start accepted in IDLE.
  - The data is still reduced mod Q.
- Undefined: no range_err port; out-of-range inputs are silently reduced mod Q.

Test Plan:
All scenarios use N=8, LOG_N=3, Q=17, DATA_WIDTH=5, N_INV=15, with a ROM giving omega=2 (forward) and omega^-1=9 (inverse).
- Impulse NTT: load [1,0,0,0,0,0,0,0], inverse=0 -> out [1,1,1,1,1,1,1,1]; busy for exactly 8+12+8 cycles with out_ready=1; one done pulse.
- Constant NTT: load all 1s -> out [8,0,0,0,0,0,0,0]. Check COMPUTE = 12 cycles from last in_ready to first out_valid.
- INTT round trip: load [8,0,...,0], inverse=1 -> out all 1s. Also check tw_inv=1 and that the SCALE pass adds 8 cycles.
- Backpressure: randomly toggle in_valid and out_ready with the impulse vector -> identical output, out_data stable while stalled, no lost or duplicated coefficients.
- Reset mid-COMPUTE: assert reset at the 5th compute cycle -> busy=0, out_valid=0 asynchronously, no done. A subsequent constant-vector run gives [8,0,...,0].
- Range check (NTT_RANGE_CHECK_EN): load [18,0,...,0] -> range_err=1 and out all 1s. The next start clears range_err.

Source files
------------

// File: rtl/ntt_engine.sv
// ntt_engine: iterative radix-2 NTT/INTT with streaming load/unload; NTT_RANGE_CHECK_EN adds range_err.
module ntt_engine #(
  parameter int N          = 256,
  parameter int LOG_N      = 8,
  parameter int Q          = 12289,
  parameter int DATA_WIDTH = 14,
  parameter int N_INV      = 12241
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  inverse,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [LOG_N-2:0]      tw_addr,
  output logic                  tw_inv,
  input  logic [DATA_WIDTH-1:0] tw_data,
  output logic                  busy,
  output logic                  done
`ifdef NTT_RANGE_CHECK_EN
  , output logic                range_err
`endif
);
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(LOG_N);
  localparam logic [DW-1:0]    QD = DW'(Q);
  localparam logic [DW:0]      QS = (DW+1)'(Q);
  localparam logic [2*DW-1:0]  QP = (2*DW)'(Q);
  localparam logic [DW-1:0]    NI = DW'(N_INV);
  localparam logic [LOG_N-1:0] CLAST = LOG_N'(N-1);
  localparam logic [LOG_N-2:0] BLAST = '1;
  localparam logic [SW-1:0]    SLAST = SW'(LOG_N-1);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, SCALE, UNLOAD} state_t;
  state_t state, state_n;

  logic [DW-1:0]    mem [N];
  logic [LOG_N-1:0] cnt, rev, half, k, j, jh;
  logic [LOG_N-2:0] bf;
  logic [SW-1:0]    st;
  logic [DW-1:0]    u, v, t, lm, sc;
  logic [2*DW-1:0]  prod, sprod;
  logic [DW:0]      sum, dif, s_red, d_red;
  logic             in_fire, out_fire;

  assign busy      = state != IDLE;
  assign in_ready  = state == LOAD;
  assign out_valid = state == UNLOAD;
  assign in_fire   = in_ready && in_valid;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = out_valid ? mem[cnt] : '0;

  // Butterfly b of stage st pairs j = 2b - (b mod half) with j + half.
  always_comb begin
    for (int i = 0; i < LOG_N; i++) rev[i] = cnt[LOG_N-1-i];
    half    = LOG_N'(1) << st;
    k       = LOG_N'(bf) & (half - 1'b1);
    j       = {bf, 1'b0} - k;
    jh      = j + half;
    tw_addr = state == COMPUTE ? (LOG_N-1)'(k << (LOG_N - 1 - st)) : '0;
    u       = mem[j];
    v       = mem[jh];
    prod    = {{DW{1'b0}}, v} * {{DW{1'b0}}, tw_data};
    t       = DW'(prod % QP);
    sum     = {1'b0, u} + {1'b0, t};
    dif     = {1'b0, u} + QS - {1'b0, t};
    s_red   = sum >= QS ? sum - QS : sum;
    d_red   = dif >= QS ? dif - QS : dif;
    sprod   = {{DW{1'b0}}, mem[cnt]} * {{DW{1'b0}}, NI};
    sc      = DW'(sprod % QP);
    lm      = in_data % QD;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = in_fire && cnt == CLAST ? COMPUTE : LOAD;
      COMPUTE: state_n = bf == BLAST && st == SLAST ? (tw_inv ? SCALE : UNLOAD) : COMPUTE;
      SCALE:   state_n = cnt == CLAST ? UNLOAD : SCALE;
      UNLOAD:  state_n = out_fire && cnt == CLAST ? IDLE : UNLOAD;
      default: state_n = IDLE;
    endcase
  end

  // cnt is LOG_N wide, so it wraps back to 0 at the end of every N-long phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      bf     <= '0;
      st     <= '0;
      tw_inv <= 1'b0;
      done   <= 1'b0;
`ifdef NTT_RANGE_CHECK_EN
      range_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done  <= out_fire && cnt == CLAST;
      if (state == IDLE && start) tw_inv <= inverse;
      if (in_fire || out_fire || state == SCALE) cnt <= cnt + 1'b1;
      if (state == COMPUTE) begin
        bf <= bf + 1'b1;
        if (bf == BLAST) st <= st == SLAST ? '0 : st + 1'b1;
      end
`ifdef NTT_RANGE_CHECK_EN
      if (state == IDLE && start) range_err <= 1'b0;
      else if (in_fire && in_data >= QD) range_err <= 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[rev] <= lm;
    else if (state == COMPUTE) begin
      mem[j]  <= DW'(s_red);
      mem[jh] <= DW'(d_red);
    end else if (state == SCALE) mem[cnt] <= sc;
  end
endmodule
